keypad_scanner: RTL and testbench

Active scanning side of the 4x4 matrix keypad interface. Drives `col` one-hot and samples `fila`. Detects, debounces and decodes one keypress at a time into a 4-bit key code with a single-cycle valid strobe. Feeds the character-entry logic that fills the 7-segment buffer and the motor command sequencer.

---
 rtl/keypad_pkg.sv | 64 ++++++
 rtl/keypad_sync.sv | 24 ++
 rtl/keypad_scanner.sv | 121 ++++++++++++
 tb/tb_keypad_scanner.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// keypad_pkg: shared FSM state codes, key code constants and decode helpers
// for the 4x4 matrix keypad scanner. Pure combinational helpers, no state.
// Row/column indices are 0-based; column 0 is the leftmost keypad column.
package keypad_pkg;

  localparam logic [1:0] ST_SCAN     = 2'd0;
  localparam logic [1:0] ST_DEBOUNCE = 2'd1;
  localparam logic [1:0] ST_PRESSED  = 2'd2;
  localparam logic [1:0] ST_RELEASE  = 2'd3;

  localparam logic [3:0] KEY_A    = 4'd10;
  localparam logic [3:0] KEY_B    = 4'd11;
  localparam logic [3:0] KEY_C    = 4'd12;
  localparam logic [3:0] KEY_D    = 4'd13;
  localparam logic [3:0] KEY_STAR = 4'd14;
  localparam logic [3:0] KEY_HASH = 4'd15;

  // Key code for a (row, column) position on the keypad face.
  function automatic logic [3:0] decode_key(input logic [1:0] row, input logic [1:0] column);
    logic [3:0] code;
    code = 4'd0;
    case ({row, column})
      4'b00_00: code = 4'd1;
      4'b00_01: code = 4'd2;
      4'b00_10: code = 4'd3;
      4'b00_11: code = KEY_A;
      4'b01_00: code = 4'd4;
      4'b01_01: code = 4'd5;
      4'b01_10: code = 4'd6;
      4'b01_11: code = KEY_B;
      4'b10_00: code = 4'd7;
      4'b10_01: code = 4'd8;
      4'b10_10: code = 4'd9;
      4'b10_11: code = KEY_C;
      4'b11_00: code = KEY_STAR;
      4'b11_01: code = 4'd0;
      4'b11_10: code = KEY_HASH;
      4'b11_11: code = KEY_D;
      default:  code = 4'd0;
    endcase
    return code;
  endfunction

  // Lowest-index active row wins when several rows read high together.
  function automatic logic [1:0] low_row(input logic [3:0] rows);
    logic [1:0] idx;
    idx = 2'd3;
    if (rows[0])      idx = 2'd0;
    else if (rows[1]) idx = 2'd1;
    else if (rows[2]) idx = 2'd2;
    return idx;
  endfunction

  // Index of the driven column from its one-hot drive pattern.
  function automatic logic [1:0] col_index(input logic [3:0] onehot);
    logic [1:0] idx;
    idx = 2'd0;
    if (onehot[1])      idx = 2'd1;
    else if (onehot[2]) idx = 2'd2;
    else if (onehot[3]) idx = 2'd3;
    return idx;
  endfunction

endpackage

// File: rtl/keypad_sync.sv
// keypad_sync: two-flop synchronizer bringing the raw keypad rows into clk.
// Latency: 2 cycles from d to q.
// No backpressure; samples every cycle, synchronous active-high reset.
module keypad_sync (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] d,
  output logic [3:0] q
);

  logic [3:0] meta;

  // Two back-to-back flops give the first stage a full cycle to resolve.
  always_ff @(posedge clk) begin
    if (reset) begin
      meta <= 4'd0;
      q    <= 4'd0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/keypad_scanner.sv
// keypad_scanner: drives columns one-hot, samples rows, debounces and decodes one key.
// Latency: key_valid rises DEBOUNCE_CNT+1 cycles after the row sample that saw the press.
// No backpressure: key_valid is a one-cycle strobe; consumers must take it when it fires.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV     = 50000,
  parameter int DEBOUNCE_CNT = 500000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] fila,
  output logic [3:0] col,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  localparam int SW = $clog2(SCAN_DIV) + 1;
  localparam int DW = $clog2(DEBOUNCE_CNT) + 1;
  localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);
  localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CNT - 1);

  logic [3:0]    rows_s;
  logic [1:0]    state;
  logic [SW-1:0] dwell_cnt;
  logic [DW-1:0] db_cnt;
  logic [3:0]    rows_lat;
  logic [1:0]    col_lat;
  logic [3:0]    col_next;

  keypad_sync u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (fila),
    .q     (rows_s)
  );

  // Next column in the left rotation 0001 -> 0010 -> 0100 -> 1000 -> 0001.
  always_comb begin
    col_next = {col[2:0], col[3]};
  end

  // Scan / debounce / press / release sequencing. Counters are cleared on
  // every state change, so they never need to wrap. The debounce counter
  // finishes one cycle after it has seen DEBOUNCE_CNT matching samples'
  // worth of increments, and PRESSED spends one more cycle registering the
  // outputs, which places key_valid DEBOUNCE_CNT+1 cycles after the sample.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_SCAN;
      col       <= 4'b0001;
      dwell_cnt <= '0;
      db_cnt    <= '0;
      rows_lat  <= 4'd0;
      col_lat   <= 2'd0;
      key_code  <= 4'd0;
      key_valid <= 1'b0;
      key_held  <= 1'b0;
    end else begin
      key_valid <= 1'b0;
      case (state)
        ST_SCAN: begin
          if (dwell_cnt == SCAN_LAST) begin
            dwell_cnt <= '0;
            if (rows_s == 4'd0) begin
              col <= col_next;
            end else begin
              // Keep the whole row pattern; priority is applied at decode.
              rows_lat <= rows_s;
              col_lat  <= col_index(col);
              db_cnt   <= '0;
              state    <= ST_DEBOUNCE;
            end
          end else begin
            dwell_cnt <= dwell_cnt + 1'b1;
          end
        end
        ST_DEBOUNCE: begin
          if (rows_s != rows_lat) begin
            // Bounce or glitch: drop it silently and move on to the next column.
            db_cnt    <= '0;
            dwell_cnt <= '0;
            col       <= col_next;
            state     <= ST_SCAN;
          end else if (db_cnt == DB_LAST) begin
            db_cnt <= '0;
            state  <= ST_PRESSED;
          end else begin
            db_cnt <= db_cnt + 1'b1;
          end
        end
        ST_PRESSED: begin
          key_valid <= 1'b1;
          key_held  <= 1'b1;
          key_code  <= decode_key(low_row(rows_lat), col_lat);
          db_cnt    <= '0;
          state     <= ST_RELEASE;
        end
        ST_RELEASE: begin
          // Any row activity, including a second key, restarts the release count.
          if (rows_s != 4'd0) begin
            db_cnt <= '0;
          end else if (db_cnt == DB_LAST) begin
            key_held  <= 1'b0;
            db_cnt    <= '0;
            dwell_cnt <= '0;
            col       <= col_next;
            state     <= ST_SCAN;
          end else begin
            db_cnt <= db_cnt + 1'b1;
          end
        end
        default: begin
          state <= ST_SCAN;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: directed checks of scanning, debounce, decode and reset.
// Uses SCAN_DIV=4, DEBOUNCE_CNT=3 so every event lands on a known cycle.
// Inputs change 1 ns after a rising edge; outputs are read at the same point.
module tb_keypad_scanner;

  logic       clk;
  logic       reset;
  logic [3:0] fila;
  logic [3:0] col;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_held;

  int n_checks = 0;
  int n_errors = 0;
  int strobe_cnt = 0;

  keypad_scanner #(
    .SCAN_DIV     (4),
    .DEBOUNCE_CNT (3)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .fila      (fila),
    .col       (col),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_held  (key_held)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count strobes in mid-cycle, away from the edge that changes key_valid.
  always @(negedge clk) begin
    if (key_valid) strobe_cnt = strobe_cnt + 1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Wait for the tick on which col switches to target, i.e. its dwell restarts.
  task automatic wait_col_change(input logic [3:0] target);
    logic [3:0] prev;
    logic       found;
    prev  = col;
    found = 1'b0;
    for (int i = 0; i < 64 && !found; i++) begin
      tick();
      if (col == target && prev != target) found = 1'b1;
      prev = col;
    end
    check("col_wait", 32'(found), 32'd1);
  endtask

  // Press on column 'target' right as it starts its dwell, hold, then release.
  task automatic press_key(input logic [3:0] target, input logic [3:0] rows,
                           input logic [3:0] exp_code, input string tag);
    int s0;
    logic [3:0] nxt;
    nxt = {target[2:0], target[3]};
    wait_col_change(target);
    s0   = strobe_cnt;
    fila = rows;
    repeat (7) tick();
    check({tag, "_early_valid"}, 32'(key_valid), 32'd0);
    tick();
    check({tag, "_valid"}, 32'(key_valid), 32'd1);
    check({tag, "_code"}, 32'(key_code), 32'(exp_code));
    check({tag, "_held_on"}, 32'(key_held), 32'd1);
    tick();
    check({tag, "_valid_drop"}, 32'(key_valid), 32'd0);
    check({tag, "_code_kept"}, 32'(key_code), 32'(exp_code));
    repeat (2) tick();
    fila = 4'd0;
    repeat (4) tick();
    check({tag, "_held_late"}, 32'(key_held), 32'd1);
    check({tag, "_col_frozen"}, 32'(col), 32'(target));
    tick();
    check({tag, "_held_off"}, 32'(key_held), 32'd0);
    check({tag, "_col_next"}, 32'(col), 32'(nxt));
    check({tag, "_strobes"}, 32'(strobe_cnt - s0), 32'd1);
  endtask

  initial begin
    int s0;
    logic [3:0] exp_col;
    fila  = 4'd0;
    reset = 1'b1;
    repeat (3) tick();
    check("rst_col", 32'(col), 32'h1);
    check("rst_code", 32'(key_code), 32'h0);
    check("rst_valid", 32'(key_valid), 32'h0);
    check("rst_held", 32'(key_held), 32'h0);
    reset = 1'b0;

    // Idle scan: each column dwells 4 cycles, wrapping back to 0001.
    for (int k = 1; k <= 16; k++) begin
      tick();
      exp_col = 4'b0001 << ((k / 4) % 4);
      check("scan_col", 32'(col), 32'(exp_col));
    end

    // A, B, C on the rightmost column, one strobe each.
    press_key(4'b1000, 4'b0001, 4'd10, "key_a");
    press_key(4'b1000, 4'b0010, 4'd11, "key_b");
    press_key(4'b1000, 4'b0100, 4'd12, "key_c");

    // Two-cycle glitch: enters debounce, aborts, scan moves on with no strobe.
    wait_col_change(4'b1000);
    s0 = strobe_cnt;
    tick();
    fila = 4'b0001;
    repeat (2) tick();
    fila = 4'd0;
    repeat (2) tick();
    check("glitch_col_frozen", 32'(col), 32'h8);
    tick();
    check("glitch_col_next", 32'(col), 32'h1);
    repeat (8) tick();
    check("glitch_strobes", 32'(strobe_cnt - s0), 32'd0);
    check("glitch_held", 32'(key_held), 32'd0);

    // '5', then a second row joins while held: still exactly one strobe.
    wait_col_change(4'b0010);
    s0   = strobe_cnt;
    fila = 4'b0010;
    repeat (8) tick();
    check("k5_valid", 32'(key_valid), 32'd1);
    check("k5_code", 32'(key_code), 32'd5);
    tick();
    fila = 4'b0011;
    repeat (10) tick();
    check("k5_held_two", 32'(key_held), 32'd1);
    check("k5_one_strobe", 32'(strobe_cnt - s0), 32'd1);
    fila = 4'd0;
    repeat (4) tick();
    check("k5_held_late", 32'(key_held), 32'd1);
    tick();
    check("k5_held_off", 32'(key_held), 32'd0);
    check("k5_code_kept", 32'(key_code), 32'd5);
    check("k5_total_strobes", 32'(strobe_cnt - s0), 32'd1);

    // Two rows at the sample: row1 beats row2 on column 2 -> '6'.
    press_key(4'b0100, 4'b0110, 4'd6, "prio_6");
    // Bottom-left corner is '*'.
    press_key(4'b0001, 4'b1000, 4'd14, "key_star");

    // Reset in the middle of debounce.
    wait_col_change(4'b1000);
    s0   = strobe_cnt;
    fila = 4'b0001;
    repeat (5) tick();
    reset = 1'b1;
    fila  = 4'd0;
    tick();
    check("rst_db_col", 32'(col), 32'h1);
    check("rst_db_held", 32'(key_held), 32'd0);
    check("rst_db_valid", 32'(key_valid), 32'd0);
    reset = 1'b0;
    repeat (12) tick();
    check("rst_db_strobes", 32'(strobe_cnt - s0), 32'd0);

    // Reset while waiting for release.
    wait_col_change(4'b0100);
    fila = 4'b0001;
    repeat (9) tick();
    check("rst_rel_held_before", 32'(key_held), 32'd1);
    check("rst_rel_code_before", 32'(key_code), 32'd3);
    s0    = strobe_cnt;
    reset = 1'b1;
    fila  = 4'd0;
    tick();
    check("rst_rel_col", 32'(col), 32'h1);
    check("rst_rel_held", 32'(key_held), 32'd0);
    check("rst_rel_valid", 32'(key_valid), 32'd0);
    check("rst_rel_code", 32'(key_code), 32'd0);
    reset = 1'b0;
    repeat (12) tick();
    check("rst_rel_strobes", 32'(strobe_cnt - s0), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
